alu_seq: RTL

- Parametrised, handshaked, multi-cycle successor to the 8-bit combinational datapath ALU. Covers the same five operation classes plus arithmetic shift and rotate.
- Shifts are variable-distance and iterative, one bit per cycle. Results and flags are registered.
- Sits between the register-file read stage and writeback; the control unit drives it with valid/ready.

---
 rtl/alu_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked multi-cycle ALU.
// XOR / BEQ / ADD / AND finish in one cycle. Logical shift, arithmetic shift
// and rotate move one bit per cycle over a signed distance taken from input2.
// Result and flags are registered and held in DONE until the consumer takes them.
//
// Handshake: a request is accepted on a rising edge where in_valid && in_ready.
// A result is consumed on a rising edge where out_valid && out_ready. in_ready
// is high only in IDLE, and out_valid is high only in DONE, so the two never
// overlap.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SAW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       instruction,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [SAW-1:0] CNT_ONE = {{(SAW-1){1'b0}}, 1'b1};

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_result, r_work;
  logic             r_zero, r_carry, r_negative, r_left;
  logic [1:0]       r_op;
  logic [SAW-1:0]   r_cnt;

  logic [SAW-1:0]   w_field, w_mag;
  logic             w_neg, w_field_zero, w_is_shift;
  logic [WIDTH:0]   w_sum, w_first, w_step;
  logic [WIDTH-1:0] w_imm, w_res;
  logic             w_imm_c, w_cy, w_commit, w_load;
  logic             w_unused;

  // One bit of shift/rotate. Returns {bit shifted out, new value}.
  // op: 00 logical, 01 arithmetic, 10 rotate.
  function automatic logic [WIDTH:0] f_step(input logic [WIDTH-1:0] v,
                                            input logic left,
                                            input logic [1:0] op);
    logic fill;
    if (left) begin
      fill = (op == 2'b10) ? v[WIDTH-1] : 1'b0;
      return {v[WIDTH-1], v[WIDTH-2:0], fill};
    end else begin
      fill = (op == 2'b10) ? v[0] : ((op == 2'b01) ? v[WIDTH-1] : 1'b0);
      return {v[0], fill, v[WIDTH-1:1]};
    end
  endfunction

  // Only the low SAW bits of input2 form the shift field.
  assign w_unused     = ^input2[WIDTH-1:SAW];
  assign w_field      = input2[SAW-1:0];
  assign w_neg        = w_field[SAW-1];
  assign w_mag        = w_neg ? ((~w_field) + CNT_ONE) : w_field;
  assign w_field_zero = (w_field == '0);
  assign w_is_shift   = (instruction == 3'b100) || (instruction == 3'b101) ||
                        (instruction == 3'b110);
  assign w_sum        = {1'b0, input1} + {1'b0, input2};

  // The accept edge already performs the first step, so a shift of |s|
  // reaches DONE after |s| edges in total.
  assign w_first      = f_step(input1, w_neg, instruction[1:0]);
  assign w_step       = f_step(r_work, r_left, r_op);

  // Single-cycle result for non-shift ops and zero-distance shifts.
  always_comb begin
    w_imm   = '0;
    w_imm_c = 1'b0;
    case (instruction)
      3'b000:  w_imm = input1 ^ input2;
      3'b001:  w_imm = (input1 == input2) ? '0 : {{(WIDTH-1){1'b0}}, 1'b1};
      3'b010:  begin w_imm = w_sum[WIDTH-1:0]; w_imm_c = w_sum[WIDTH]; end
      3'b011:  w_imm = input1 & input2;
      3'b111:  w_imm = '1;
      default: w_imm = input1;
    endcase
  end

  // Next-state logic plus the commit/load strobes for the datapath.
  always_comb begin
    w_next   = r_state;
    w_commit = 1'b0;
    w_load   = 1'b0;
    w_res    = r_result;
    w_cy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (w_is_shift && !w_field_zero) begin
            if (w_mag == CNT_ONE) begin
              w_next   = S_DONE;
              w_commit = 1'b1;
              w_res    = w_first[WIDTH-1:0];
              w_cy     = w_first[WIDTH];
            end else begin
              w_next = S_SHIFT;
              w_load = 1'b1;
            end
          end else begin
            w_next   = S_DONE;
            w_commit = 1'b1;
            w_res    = w_imm;
            w_cy     = w_imm_c;
          end
        end
      end
      S_SHIFT: begin
        if (r_cnt == CNT_ONE) begin
          w_next   = S_DONE;
          w_commit = 1'b1;
          w_res    = w_step[WIDTH-1:0];
          w_cy     = w_step[WIDTH];
        end
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Datapath: working shift register, remaining-step counter, output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_negative <= 1'b0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_left     <= 1'b0;
      r_op       <= 2'b00;
    end else begin
      if (w_commit) begin
        r_result   <= w_res;
        r_carry    <= w_cy;
        r_zero     <= (w_res == '0);
        r_negative <= w_res[WIDTH-1];
      end
      if (w_load) begin
        r_work <= w_first[WIDTH-1:0];
        r_cnt  <= w_mag - CNT_ONE;
        r_left <= w_neg;
        r_op   <= instruction[1:0];
      end else if (r_state == S_SHIFT) begin
        r_work <= w_step[WIDTH-1:0];
        r_cnt  <= r_cnt - CNT_ONE;
      end
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign result      = r_result;
  assign zero        = r_zero;
  assign carry       = r_carry;
  assign negative    = r_negative;
  assign o_dbg_state = r_state;

endmodule
